// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for the load/store data memory.
// ParityErr exists only when DATA_MEM_PARITY_EN is defined.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              Req;
  logic              WriteMem;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              Ready;
  logic              Busy;
  logic              ReadValid;
  logic [DATA_W-1:0] MemOut;
`ifdef DATA_MEM_PARITY_EN
  logic              ParityErr;
`endif

  modport master (
    output Req, WriteMem, Address, WriteData,
    input  Ready, Busy, ReadValid, MemOut
`ifdef DATA_MEM_PARITY_EN
    , input ParityErr
`endif
  );

  modport slave (
    input  Req, WriteMem, Address, WriteData,
    output Ready, Busy, ReadValid, MemOut
`ifdef DATA_MEM_PARITY_EN
    , output ParityErr
`endif
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory with 1-cycle registered reads and optional post-reset clear.
// Define DATA_MEM_PARITY_EN to add per-word even parity and ParityErr.
module data_mem_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic           CLK,
  input logic           RST_N,
  data_mem_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RST   =
    CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, busy_q, rvalid_q;
  logic [DATA_W-1:0] mout_q, mout_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clearing, rd_acc, wr_acc, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rd_word;

  always_comb begin
    clearing = (state_q == ST_CLEAR);
    rd_acc   = ready_q & bus.Req & ~bus.WriteMem;
    wr_acc   = ready_q & bus.Req & bus.WriteMem;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (clearing) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_RUN;
    end
    rd_word = mem_q[bus.Address];
    mout_d  = rd_acc ? rd_word : mout_q;
    wr_en   = clearing | wr_acc;
    wr_addr = clearing ? cnt_q : bus.Address;
    wr_data = clearing ? '0 : bus.WriteData;
  end

  // Ready/Busy are registered decodes of the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= CLEAR_ON_RESET;
      rvalid_q <= 1'b0;
      mout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= (state_d == ST_RUN);
      busy_q   <= (state_d == ST_CLEAR);
      rvalid_q <= rd_acc;
      mout_q   <= mout_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign bus.Ready     = ready_q;
  assign bus.Busy      = busy_q;
  assign bus.ReadValid = rvalid_q;
  assign bus.MemOut    = mout_q;

`ifdef DATA_MEM_PARITY_EN
  logic par_q [DEPTH];
  logic perr_q, perr_d, wr_par;

  always_comb begin
    wr_par = clearing ? 1'b0 : ^bus.WriteData;
    perr_d = rd_acc &
      ((^rd_word) != par_q[bus.Address]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) par_q[wr_addr] <= wr_par;
  end

  assign bus.ParityErr = perr_q;
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: random and directed traffic against an array model.
// Also covers a CLEAR_ON_RESET=0, 16x16 instance.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus2 ();

  data_mem_ctrl #(
    .DATA_W(8), .ADDR_W(8), .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus)
  );

  data_mem_ctrl #(
    .DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)
  ) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .bus(bus2)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        perr;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  model [256];
  bit          forced [256];
  logic [7:0]  last = 8'h00;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 256; i++) begin
      model[i]  = 8'h00;
      forced[i] = 1'b0;
    end
    q.delete();
    last = 8'h00;
  endtask

  // Monitor: pops the scoreboard whenever a read completes
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ReadValid) begin
        if (q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(e.cyc));
          chk("rd_data", bus.MemOut, e.data);
`ifdef DATA_MEM_PARITY_EN
          chk("rd_perr", bus.ParityErr, e.perr);
`endif
          last = e.data;
        end
      end else begin
        chk("memout_hold", bus.MemOut, last);
`ifdef DATA_MEM_PARITY_EN
        chk("perr_idle", bus.ParityErr, 0);
`endif
      end
    end
  end

  task automatic op(input logic w, input logic [7:0] a,
                    input logic [7:0] d);
    exp_t e;
    bus.Req = 1'b1;
    bus.WriteMem = w;
    bus.Address = a;
    bus.WriteData = d;
    if (w) begin
      model[a]  = d;
      forced[a] = 1'b0;
    end else begin
      e.cyc  = cyc + 1;
      e.data = model[a];
      e.perr = forced[a];
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Req = 1'b0;
      bus.WriteMem = 1'($urandom_range(0, 1));
      bus.Address = 8'($urandom);
      bus.WriteData = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic wait_sweep(input string nm);
    int n = 0;
    bit bad = 1'b0;
    while (!bus.Ready && n < 400) begin
      if (!bus.Busy) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk(nm, n, 256);
    chk({nm, "_busy"}, bad, 0);
    chk({nm, "_busy_off"}, bus.Busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.Req = 1'b0; bus.WriteMem = 1'b0;
    bus.Address = '0; bus.WriteData = '0;
    bus2.Req = 1'b0; bus2.WriteMem = 1'b0;
    bus2.Address = '0; bus2.WriteData = '0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.Ready, 0);
    chk("rst_busy", bus.Busy, 1);
    chk("rst_rvalid", bus.ReadValid, 0);
    chk("rst_memout", bus.MemOut, 0);
    chk("rst2_ready", bus2.Ready, 0);
    chk("rst2_busy", bus2.Busy, 0);
    rst_n = 1'b1;
    fork
      wait_sweep("sweep1");
      begin
        @(negedge clk);
        chk("dut2_ready_first", bus2.Ready, 1);
      end
    join

    op(0, 8'h00, 0); op(0, 8'h7F, 0); op(0, 8'hFF, 0);
    idle(1);
    op(1, 8'h10, 8'hA5); op(0, 8'h10, 0);
    idle(1);
    op(1, 8'h01, 8'h11); op(1, 8'h02, 8'h22);
    op(1, 8'h03, 8'h33);
    op(0, 8'h01, 0); op(0, 8'h02, 0); op(0, 8'h03, 0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ?
          8'($urandom) : 8'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) idle(1);
      else op(1'($urandom_range(0, 1)), a, 8'($urandom));
    end
    idle(2);

`ifdef DATA_MEM_PARITY_EN
    op(1, 8'h20, 8'h01);
    u_dut.par_q[8'h20] = 1'b0;
    forced[8'h20] = 1'b1;
    op(0, 8'h20, 0);
    op(0, 8'h10, 0);
    idle(2);
`endif

    bus.Req = 1'b1; bus.WriteMem = 1'b0; bus.Address = 8'h03;
    @(posedge clk);
    #1;
    bus.Req = 1'b0;
    chk("pre_rst_rvalid", bus.ReadValid, 1);
    chk("pre_rst_memout", bus.MemOut, model[8'h03]);
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("midrd_rvalid", bus.ReadValid, 0);
    chk("midrd_memout", bus.MemOut, 0);
    chk("midrd_ready", bus.Ready, 0);
    chk("midrd_busy", bus.Busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (101) @(negedge clk);
    chk("sweep_mid_busy", bus.Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midsw_ready", bus.Ready, 0);
    chk("midsw_busy", bus.Busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("sweep2");
    for (int i = 0; i < 12; i++)
      op(0, 8'($urandom_range(0, 31)), 0);
    op(0, 8'h10, 0); op(0, 8'hFF, 0);
    idle(3);

    bus2.Req = 1'b1; bus2.WriteMem = 1'b1;
    bus2.Address = 4'hF; bus2.WriteData = 16'hBEEF;
    @(negedge clk);
    bus2.WriteMem = 1'b0;
    @(negedge clk);
    bus2.Req = 1'b0;
    chk("dut2_rvalid", bus2.ReadValid, 1);
    chk("dut2_memout", bus2.MemOut, 16'hBEEF);
    @(negedge clk);
    chk("dut2_rvalid_drop", bus2.ReadValid, 0);

    idle(2);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
